// File: rtl/uart_apb_decoder.sv
// uart_apb_decoder: registered APB slave decoder for the UART register bank.
// Optional access timeout: define UART_APB_TIMEOUT_EN.
module uart_apb_decoder #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                enable,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [NUM_REGS-1:0] reg_busy,
  output logic [NUM_REGS-1:0] sel_reg,
  output logic                wr_stb,
  output logic                rd_stb,
  output logic                ready,
  output logic                slverr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                wr_q, wr_d;
  logic [NUM_REGS-1:0] sel_reg_d;
  logic                ready_d;
  logic                slverr_d;
  logic                wr_stb_d;
  logic                rd_stb_d;
  logic                start;
  logic                setup;
  logic                hit_now;
  logic                hit_q;
  logic                busy_sel;
  logic [31:0]         addr_ext;
  logic [NUM_REGS-1:0] dec;

  assign setup    = sel & ~enable;
  assign addr_ext = 32'(addr);
  assign hit_now  = addr_ext < 32'(NUM_REGS);
  assign dec      = NUM_REGS'(1) << addr[IDX_W-1:0];
  // The held one-hot select doubles as the latched hit flag and index
  assign hit_q    = |sel_reg;
  assign busy_sel = |(reg_busy & sel_reg);

`ifdef UART_APB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  // Count access cycles from entry, saturating; cleared outside ACCESS
  always_comb begin
    tcnt_d = '0;
    if (state_q == ACCESS && tcnt_q != '1)
      tcnt_d = tcnt_q + 1'b1;
  end

  // Access-cycle counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    sel_reg_d = sel_reg;
    wr_d      = wr_q;
    wcnt_d    = wcnt_q;
    ready_d   = ready;
    slverr_d  = 1'b0;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        start   = setup;
      end
      ACCESS: begin
        if (!sel) begin
          state_d   = IDLE;
          sel_reg_d = '0;
          ready_d   = 1'b1;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (!hit_q || !busy_sel) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          slverr_d = ~hit_q;
          wr_stb_d = hit_q & wr_q;
          rd_stb_d = hit_q & ~wr_q;
        end
`ifdef UART_APB_TIMEOUT_EN
        else if (tcnt_q >= TCNT_W'(TIMEOUT - 1)) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
        end
`endif
      end
      DONE: begin
        start = setup;
        if (!setup) begin
          state_d   = IDLE;
          sel_reg_d = '0;
          ready_d   = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        sel_reg_d = '0;
      end
    endcase
    if (start) begin
      state_d   = ACCESS;
      sel_reg_d = hit_now ? dec : '0;
      wr_d      = write;
      wcnt_d    = 4'(WAIT_CYCLES);
      ready_d   = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      wr_q    <= 1'b0;
      sel_reg <= '0;
      ready   <= 1'b0;
      slverr  <= 1'b0;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      sel_reg <= sel_reg_d;
      ready   <= ready_d;
      slverr  <= slverr_d;
      wr_stb  <= wr_stb_d;
      rd_stb  <= rd_stb_d;
    end
  end

endmodule

// File: tb/tb_uart_apb_decoder.sv
// tb_uart_apb_decoder: vector table plus hand sequences
// for the UART APB register decoder.
module tb_uart_apb_decoder;

  localparam int NR   = 4;
  localparam int AW   = 10;
  localparam int WAIT = 1;
  localparam int TMO  = 8;

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
    logic [NR-1:0] bm;
    int            bl;
    logic [NR-1:0] es;
    logic          ew;
    logic          er;
    logic          ee;
    int            lat;
  } vec_t;

  typedef struct {
    logic [NR-1:0] es;
    logic          ew;
    logic          er;
    logic          ee;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic          enable = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [NR-1:0] reg_busy = '0;
  logic [NR-1:0] sel_reg;
  logic          wr_stb;
  logic          rd_stb;
  logic          ready;
  logic          slverr;

  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  uart_apb_decoder #(
    .NUM_REGS(NR),
    .ADDR_W(AW),
    .WAIT_CYCLES(WAIT),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .enable(enable),
    .write(write),
    .addr(addr),
    .reg_busy(reg_busy),
    .sel_reg(sel_reg),
    .wr_stb(wr_stb),
    .rd_stb(rd_stb),
    .ready(ready),
    .slverr(slverr)
  );

  always @(posedge clk) begin
    wr_cnt <= wr_cnt + int'(wr_stb);
    rd_cnt <= rd_cnt + int'(rd_stb);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string nm, input int lim,
                            output int k);
    k = 0;
    while (!ready && k < lim) begin
      k++;
      cyc();
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL %s.bound: got ready=0 want ready=1", nm);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int   k;
    int   w0;
    int   r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    sel = 1'b1;
    enable = 1'b0;
    write = v.w;
    addr = v.a;
    reg_busy = (v.bl > 0) ? v.bm : '0;
    e.es = v.es;
    e.ew = v.ew;
    e.er = v.er;
    e.ee = v.ee;
    e.lat = v.lat;
    sb.push_back(e);
    cyc();
    chk({nm, ".sel"}, 32'(sel_reg), 32'(v.es));
    chk({nm, ".busy0"}, 32'(ready), 0);
    enable = 1'b1;
    k = 0;
    while (!ready && k < 200) begin
      k++;
      reg_busy = (v.bl > 0 && k <= WAIT + v.bl) ? v.bm : '0;
      cyc();
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s.sb: got empty want entry", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".lat"}, 32'(k), 32'(e.lat));
      chk({nm, ".wr"}, 32'(wr_stb), 32'(e.ew));
      chk({nm, ".rd"}, 32'(rd_stb), 32'(e.er));
      chk({nm, ".err"}, 32'(slverr), 32'(e.ee));
      chk({nm, ".hold"}, 32'(sel_reg), 32'(e.es));
    end
    sel = 1'b0;
    enable = 1'b0;
    reg_busy = '0;
    cyc();
    chk({nm, ".idle"}, {sel_reg, wr_stb, rd_stb, slverr, ready},
        32'b1);
    chk({nm, ".nwr"}, 32'(wr_cnt - w0), 32'(v.ew));
    chk({nm, ".nrd"}, 32'(rd_cnt - r0), 32'(v.er));
  endtask

  initial begin
    int k;
    int w0;
    int r0;
    int hi;

    vecs[0]  = '{10'd2,    1'b1, 4'b0000, 0, 4'b0100, 1'b1, 1'b0, 1'b0, WAIT+1};
    vecs[1]  = '{10'd7,    1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 1'b1, WAIT+1};
    vecs[2]  = '{10'd0,    1'b0, 4'b0001, 5, 4'b0001, 1'b0, 1'b1, 1'b0, WAIT+6};
    vecs[3]  = '{10'd3,    1'b1, 4'b0000, 0, 4'b1000, 1'b1, 1'b0, 1'b0, WAIT+1};
    vecs[4]  = '{10'd1,    1'b0, 4'b0000, 0, 4'b0010, 1'b0, 1'b1, 1'b0, WAIT+1};
    vecs[5]  = '{10'd4,    1'b1, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 1'b1, WAIT+1};
    vecs[6]  = '{10'd1023, 1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 1'b1, WAIT+1};
    vecs[7]  = '{10'd516,  1'b1, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 1'b1, WAIT+1};
    vecs[8]  = '{10'd3,    1'b0, 4'b0111, 3, 4'b1000, 1'b0, 1'b1, 1'b0, WAIT+1};
    vecs[9]  = '{10'd7,    1'b1, 4'b1111, 5, 4'b0000, 1'b0, 1'b0, 1'b1, WAIT+1};
    vecs[10] = '{10'd2,    1'b1, 4'b0100, 2, 4'b0100, 1'b1, 1'b0, 1'b0, WAIT+3};

    // reset state and release
    repeat (3) @(negedge clk);
    chk("rst.out", {sel_reg, wr_stb, rd_stb, slverr, ready}, 0);
    rst = 1'b1;
    #1;
    chk("rst.rel0", 32'(ready), 0);
    @(negedge clk);
    cyc();
    chk("rst.rel1", 32'(ready), 1);

    // table
    for (int i = 0; i < 11; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // reset mid-access
    w0 = wr_cnt;
    sel = 1'b1;
    enable = 1'b0;
    write = 1'b1;
    addr = 10'd2;
    cyc();
    enable = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst.out", {sel_reg, wr_stb, rd_stb, slverr, ready}, 0);
    sel = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    cyc();
    chk("mrst.nostb", 32'(wr_cnt - w0), 0);
    rst = 1'b1;
    cyc();
    chk("mrst.rdy", 32'(ready), 1);

    // back-to-back write then read
    w0 = wr_cnt;
    r0 = rd_cnt;
    sel = 1'b1;
    enable = 1'b0;
    write = 1'b1;
    addr = 10'd1;
    cyc();
    chk("b2b.sel1", 32'(sel_reg), 32'b0010);
    enable = 1'b1;
    wait_ready("b2b.w", 20, k);
    chk("b2b.wr", 32'(wr_stb), 1);
    enable = 1'b0;
    write = 1'b0;
    addr = 10'd3;
    cyc();
    chk("b2b.rdy0", 32'(ready), 0);
    chk("b2b.sel2", 32'(sel_reg), 32'b1000);
    chk("b2b.wrclr", 32'(wr_stb), 0);
    enable = 1'b1;
    wait_ready("b2b.r", 20, k);
    chk("b2b.rd", 32'(rd_stb), 1);
    chk("b2b.err", 32'(slverr), 0);
    sel = 1'b0;
    enable = 1'b0;
    cyc();
    chk("b2b.nwr", 32'(wr_cnt - w0), 1);
    chk("b2b.nrd", 32'(rd_cnt - r0), 1);

    // abort in access
    w0 = wr_cnt;
    sel = 1'b1;
    write = 1'b1;
    addr = 10'd2;
    cyc();
    sel = 1'b0;
    cyc();
    chk("abt.rdy", 32'(ready), 1);
    chk("abt.sel", 32'(sel_reg), 0);
    cyc();
    chk("abt.nostb", 32'(wr_cnt - w0), 0);
    chk("abt.err", 32'(slverr), 0);

    // busy stuck
`ifdef UART_APB_TIMEOUT_EN
    run_vec('{10'd0, 1'b0, 4'b0001, 1000, 4'b0001, 1'b0, 1'b0, 1'b1, TMO},
            "tmo");
`else
    r0 = rd_cnt;
    hi = 0;
    sel = 1'b1;
    enable = 1'b0;
    write = 1'b0;
    addr = 10'd0;
    reg_busy = 4'b0001;
    cyc();
    enable = 1'b1;
    repeat (100) begin
      cyc();
      hi += int'(ready);
    end
    chk("stall.rdy", 32'(hi), 0);
    sel = 1'b0;
    enable = 1'b0;
    reg_busy = '0;
    cyc();
    chk("stall.abt", 32'(ready), 1);
    cyc();
    chk("stall.nrd", 32'(rd_cnt - r0), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
